// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and defaults for the fetch PC unit.
package fetch_pc_unit_pkg;

  localparam int unsigned InstrWidth = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrop
  } fetch_state_e;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Jump-mux, decode and instruction-memory signals of the fetch PC unit.
interface fetch_pc_unit_if;
  import fetch_pc_unit_pkg::*;

  logic [31:0]           iNewPC;
  logic                  iRedirect;
  logic                  iStall;
  logic                  iMemAck;
  logic [InstrWidth-1:0] iMemData;
  logic [31:0]           oPC;
  logic [31:0]           oNextPC;
  logic                  oMemReq;
  logic [31:0]           oMemAddr;
  logic [InstrWidth-1:0] oInstr;
  logic [31:0]           oInstrPC;
  logic                  oInstrValid;

  // Fetch unit side.
  modport master (
    input  iNewPC, iRedirect, iStall, iMemAck, iMemData,
    output oPC, oNextPC, oMemReq, oMemAddr, oInstr, oInstrPC, oInstrValid
  );

  // Environment side (mux, decode, memory).
  modport slave (
    output iNewPC, iRedirect, iStall, iMemAck, iMemData,
    input  oPC, oNextPC, oMemReq, oMemAddr, oInstr, oInstrPC, oInstrValid
  );

endinterface

// File: rtl/fetch_pc_unit_buf.sv
// One-entry instruction/PC holding register between fetch and decode.
module fetch_pc_unit_buf
  import fetch_pc_unit_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [InstrWidth-1:0] load_instr_i,
  input  logic [31:0]           load_pc_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [InstrWidth-1:0] instr_o,
  output logic [31:0]           pc_o,
  output logic                  valid_o,
  output logic                  slot_free_o
);

  logic [InstrWidth-1:0] instr_q, instr_d;
  logic [31:0]           pc_q, pc_d;
  logic                  valid_q, valid_d;

  // Next-state: flush beats load, load beats consume, stall holds.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = load_instr_i;
      pc_d    = load_pc_i;
      valid_d = 1'b1;
    end else if (valid_q && !stall_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o     = instr_q;
  assign pc_o        = pc_q;
  assign valid_o     = valid_q;
  assign slot_free_o = !valid_q || !stall_i;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, request FSM and decode buffer.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input logic            iClk,
  input logic            iReset,
  fetch_pc_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic         req_q, req_d;

  logic         slot_free;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         accept;

  // Request/address outputs and accept decode.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc_q;
    unique case (state_q)
      StIdle: mem_req = 1'b0;
      // An already-raised request stays up; a new one needs a free slot.
      StReq:  mem_req = req_q || slot_free;
      StDrop: begin
        mem_req  = 1'b1;
        mem_addr = drop_addr_q;
      end
      default: mem_req = 1'b0;
    endcase
    accept = (state_q == StReq) && mem_req && bus.iMemAck && !bus.iRedirect;
  end

  // Next-state for FSM, PC and stale-address latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    req_d       = 1'b0;
    if (bus.iRedirect || accept) begin
      pc_d = bus.iNewPC;
    end
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (bus.iRedirect && mem_req && !bus.iMemAck) begin
          // Memory still owes us a word for the old address.
          state_d     = StDrop;
          drop_addr_d = pc_q;
        end else begin
          req_d = mem_req && !bus.iMemAck && !bus.iRedirect;
        end
      end
      StDrop: begin
        if (bus.iMemAck) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      req_q       <= req_d;
    end
  end

  fetch_pc_unit_buf u_buf (
    .clk_i        (iClk),
    .rst_i        (iReset),
    .load_i       (accept),
    .load_instr_i (bus.iMemData),
    .load_pc_i    (pc_q),
    .stall_i      (bus.iStall),
    .flush_i      (bus.iRedirect),
    .instr_o      (bus.oInstr),
    .pc_o         (bus.oInstrPC),
    .valid_o      (bus.oInstrValid),
    .slot_free_o  (slot_free)
  );

  assign bus.oPC      = pc_q;
  assign bus.oNextPC  = next_seq_pc(pc_q, 32'(PC_STEP));
  assign bus.oMemReq  = mem_req;
  assign bus.oMemAddr = mem_addr;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic        loop_en;
  logic        auto_ack;
  logic        man_ack;
  logic [31:0] man_data;
  logic [31:0] new_pc;
  logic        redirect;
  logic        stall;
  int          tests;
  int          fails;

  fetch_pc_unit_if bus ();

  // Mux loops oNextPC back; memory model acks at once with data = address.
  assign bus.iNewPC    = loop_en ? bus.oNextPC : new_pc;
  assign bus.iMemAck   = auto_ack ? bus.oMemReq : man_ack;
  assign bus.iMemData  = auto_ack ? bus.oMemAddr : man_data;
  assign bus.iRedirect = redirect;
  assign bus.iStall    = stall;

  fetch_pc_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    loop_en  = 1'b0;
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    man_data = '0;
    new_pc   = '0;
    redirect = 1'b0;
    stall    = 1'b0;
    tick();
    tick();
    chk("rst_pc", bus.oPC, 32'h0);
    chk("rst_req", 32'(bus.oMemReq), 32'h0);
    chk("rst_valid", 32'(bus.oInstrValid), 32'h0);
    chk("rst_instr", bus.oInstr, 32'h0);
    chk("rst_ipc", bus.oInstrPC, 32'h0);

    // Sequential stream with zero-wait memory.
    rst = 1'b0; loop_en = 1'b1; auto_ack = 1'b1;
    #1;
    chk("idle_req", 32'(bus.oMemReq), 32'h0);
    chk("idle_next", bus.oNextPC, 32'h4);
    tick();
    #1;
    chk("c1_req", 32'(bus.oMemReq), 32'h1);
    chk("c1_addr", bus.oMemAddr, 32'h0);
    chk("c1_valid", 32'(bus.oInstrValid), 32'h0);
    tick();
    #1;
    chk("c2_addr", bus.oMemAddr, 32'h4);
    chk("c2_valid", 32'(bus.oInstrValid), 32'h1);
    chk("c2_ipc", bus.oInstrPC, 32'h0);
    chk("c2_pc", bus.oPC, 32'h4);
    tick();

    // Three stalled cycles with 0x4 buffered.
    stall = 1'b1;
    #1;
    chk("st1_instr", bus.oInstr, 32'h4);
    chk("st1_ipc", bus.oInstrPC, 32'h4);
    chk("st1_req", 32'(bus.oMemReq), 32'h0);
    chk("st1_pc", bus.oPC, 32'h8);
    tick();
    #1;
    chk("st2_instr", bus.oInstr, 32'h4);
    chk("st2_valid", 32'(bus.oInstrValid), 32'h1);
    chk("st2_pc", bus.oPC, 32'h8);
    chk("st2_req", 32'(bus.oMemReq), 32'h0);
    tick();
    #1;
    chk("st3_instr", bus.oInstr, 32'h4);
    chk("st3_pc", bus.oPC, 32'h8);
    chk("st3_req", 32'(bus.oMemReq), 32'h0);
    tick();
    stall = 1'b0;
    #1;
    chk("rel_req", 32'(bus.oMemReq), 32'h1);
    chk("rel_addr", bus.oMemAddr, 32'h8);
    chk("rel_instr", bus.oInstr, 32'h4);
    tick();

    // Delayed ack with redirects while the stale request is pending.
    auto_ack = 1'b0; man_ack = 1'b0;
    #1;
    chk("rel2_instr", bus.oInstr, 32'h8);
    chk("rel2_ipc", bus.oInstrPC, 32'h8);
    chk("w0_addr", bus.oMemAddr, 32'hC);
    chk("w0_req", 32'(bus.oMemReq), 32'h1);
    tick();
    loop_en = 1'b0; new_pc = 32'h100; redirect = 1'b1;
    #1;
    chk("w1_valid", 32'(bus.oInstrValid), 32'h0);
    chk("w1_req", 32'(bus.oMemReq), 32'h1);
    chk("w1_addr", bus.oMemAddr, 32'hC);
    tick();
    new_pc = 32'h180;
    #1;
    chk("d1_pc", bus.oPC, 32'h100);
    chk("d1_addr", bus.oMemAddr, 32'hC);
    chk("d1_req", 32'(bus.oMemReq), 32'h1);
    chk("d1_valid", 32'(bus.oInstrValid), 32'h0);
    tick();
    redirect = 1'b0; man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
    #1;
    chk("d2_pc", bus.oPC, 32'h180);
    chk("d2_addr", bus.oMemAddr, 32'hC);
    chk("d2_req", 32'(bus.oMemReq), 32'h1);
    tick();
    man_ack = 1'b0; auto_ack = 1'b1; loop_en = 1'b1;
    #1;
    chk("dr_valid", 32'(bus.oInstrValid), 32'h0);
    chk("dr_addr", bus.oMemAddr, 32'h180);
    chk("dr_req", 32'(bus.oMemReq), 32'h1);
    tick();
    chk("dr2_valid", 32'(bus.oInstrValid), 32'h1);
    chk("dr2_instr", bus.oInstr, 32'h180);
    chk("dr2_ipc", bus.oInstrPC, 32'h180);
    chk("dr2_addr", bus.oMemAddr, 32'h184);

    // Redirect in the same cycle as the ack.
    loop_en = 1'b0; new_pc = 32'h200; redirect = 1'b1;
    tick();
    redirect = 1'b0; loop_en = 1'b1;
    #1;
    chk("ra_valid", 32'(bus.oInstrValid), 32'h0);
    chk("ra_addr", bus.oMemAddr, 32'h200);
    tick();
    chk("ra2_valid", 32'(bus.oInstrValid), 32'h1);
    chk("ra2_ipc", bus.oInstrPC, 32'h200);
    chk("ra2_instr", bus.oInstr, 32'h200);

    // PC wrap-around.
    loop_en = 1'b0; new_pc = 32'hFFFF_FFFC; redirect = 1'b1;
    tick();
    redirect = 1'b0; loop_en = 1'b1;
    #1;
    chk("wr_pc", bus.oPC, 32'hFFFF_FFFC);
    chk("wr_next", bus.oNextPC, 32'h0);
    chk("wr_addr", bus.oMemAddr, 32'hFFFF_FFFC);
    tick();
    chk("wr2_pc", bus.oPC, 32'h0);
    chk("wr2_addr", bus.oMemAddr, 32'h0);
    chk("wr2_ipc", bus.oInstrPC, 32'hFFFF_FFFC);
    chk("wr2_valid", 32'(bus.oInstrValid), 32'h1);

    // Reset while in DROP with an ack pending, then a stray ack.
    auto_ack = 1'b0; man_ack = 1'b0; loop_en = 1'b0; new_pc = 32'h300; redirect = 1'b1;
    #1;
    chk("rd_req", 32'(bus.oMemReq), 32'h1);
    tick();
    redirect = 1'b0;
    #1;
    chk("rd_pc", bus.oPC, 32'h300);
    chk("rd_addr", bus.oMemAddr, 32'h0);
    chk("rd_dreq", 32'(bus.oMemReq), 32'h1);
    chk("rd_valid", 32'(bus.oInstrValid), 32'h0);
    rst = 1'b1; man_ack = 1'b1; man_data = 32'hCAFE_F00D;
    tick();
    rst = 1'b0; man_ack = 1'b1; man_data = 32'h0000_BEEF;
    #1;
    chk("rr_pc", bus.oPC, 32'h0);
    chk("rr_req", 32'(bus.oMemReq), 32'h0);
    chk("rr_valid", 32'(bus.oInstrValid), 32'h0);
    chk("rr_instr", bus.oInstr, 32'h0);
    chk("rr_ipc", bus.oInstrPC, 32'h0);
    tick();
    man_ack = 1'b0;
    #1;
    chk("rs_valid", 32'(bus.oInstrValid), 32'h0);
    chk("rs_req", 32'(bus.oMemReq), 32'h1);
    chk("rs_addr", bus.oMemAddr, 32'h0);
    chk("rs_pc", bus.oPC, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
